line_step_gen: RTL

LINE_STEP_GEN -- requirements
Module: line_step_gen

---
 rtl/line_step_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/line_step_gen.sv
// line_step_gen: APB3-programmed two-axis Bresenham step/dir generator.
// One major-axis step per slot; the minor axis steps on error underflow.
module line_step_gen #(
  parameter int PERIOD_RST = 200,
  parameter int PERIOD_MIN = 4
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        step1,
  output logic        dir1,
  output logic        step2,
  output logic        dir2,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [15:0] P_RST = 16'(PERIOD_RST);
  localparam logic [15:0] P_MIN = 16'(PERIOD_MIN);

  state_t state, nxt;

  logic [16:0] dx, dy;
  logic [15:0] period, eff, half, slot;
  logic [15:0] major, minor, remaining;
  logic [15:0] ld_major, ld_minor;
  logic signed [17:0] err, err_sub;
  logic x_major, fx, fy, done;
  logic wr, ctrl_wr, abort, start, last;
  logic x_ge, do_minor, sx, sy;
  logic unused;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign unused  = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:17]};

  assign wr      = PSEL & PENABLE & PWRITE;
  assign ctrl_wr = wr & (PADDR[3:2] == 2'd3);
  assign abort   = ctrl_wr & PWDATA[1];
  assign start   = ctrl_wr & PWDATA[0] & ~PWDATA[1]
                 & (state == IDLE);

  assign eff  = (period < P_MIN) ? P_MIN : period;
  assign half = eff >> 1;
  assign last = (slot == eff - 16'd1);

  assign x_ge     = dx[15:0] >= dy[15:0];
  assign ld_major = x_ge ? dx[15:0] : dy[15:0];
  assign ld_minor = x_ge ? dy[15:0] : dx[15:0];

  // err stays in [0, major) between slots, so one add restores it
  assign err_sub  = err - $signed({2'b00, minor});
  assign do_minor = err_sub[17];
  assign sx       = x_major | do_minor;
  assign sy       = ~x_major | do_minor;

  always_comb begin
    PRDATA = '0;
    unique case (PADDR[3:2])
      2'd0: PRDATA = {15'd0, dx};
      2'd1: PRDATA = {15'd0, dy};
      2'd2: PRDATA = {16'd0, period};
      2'd3: PRDATA = {remaining, 14'd0, done, busy};
      default: PRDATA = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: nxt = (ld_major == '0) ? IDLE : RUN;
      RUN:  if (last && remaining == 16'd1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      dx        <= '0;
      dy        <= '0;
      period    <= P_RST;
      step1     <= 1'b0;
      step2     <= 1'b0;
      dir1      <= 1'b0;
      dir2      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
      slot      <= '0;
      remaining <= '0;
      major     <= '0;
      minor     <= '0;
      x_major   <= 1'b0;
      fx        <= 1'b0;
      fy        <= 1'b0;
    end else begin
      if (wr && !busy) begin
        unique case (PADDR[3:2])
          2'd0: dx <= PWDATA[16:0];
          2'd1: dy <= PWDATA[16:0];
          2'd2: period <= PWDATA[15:0];
          default: ;
        endcase
      end
      if (abort) begin
        busy  <= 1'b0;
        step1 <= 1'b0;
        step2 <= 1'b0;
        fx    <= 1'b0;
        fy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
          end
          LOAD: begin
            dir1      <= dx[16];
            dir2      <= dy[16];
            major     <= ld_major;
            minor     <= ld_minor;
            x_major   <= x_ge;
            err       <= $signed({3'b000, ld_major[15:1]});
            remaining <= ld_major;
            slot      <= '0;
            if (ld_major == '0) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          RUN: begin
            slot <= last ? '0 : slot + 16'd1;
            if (slot == '0) begin
              err   <= do_minor
                     ? err_sub + $signed({2'b00, major})
                     : err_sub;
              fx    <= sx;
              fy    <= sy;
              step1 <= sx;
              step2 <= sy;
            end else begin
              step1 <= fx & (slot < half);
              step2 <= fy & (slot < half);
            end
            if (last) begin
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                step1 <= 1'b0;
                step2 <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
